// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: stage enables/clears, next-PC
// select, and the mult/div occupancy FSM that feeds the D-stage stall.
module pipe_ctrl #(
  parameter int unsigned    MULT_LAT = 5,
  parameter int unsigned    DIV_LAT  = 10,
  parameter logic [31:0]    EXC_VEC  = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_req,
  input  logic        md_use_D,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        exc_req_M,
  input  logic        eret_D,
  input  logic [31:0] epc,
  output logic        en_PC,
  output logic        en_FD,
  output logic        clr_FD,
  output logic        clr_DE,
  output logic        clr_EM,
  output logic        en_MW,
  output logic        clr_MW,
  output logic [1:0]  npc_sel,
  output logic [31:0] redirect_pc,
  output logic        md_busy,
  output logic        md_done
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_EXC = 2'd1;
  localparam logic [1:0] NPC_EPC = 2'd2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  md_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_md_accept;
  logic             w_md_stall;
  logic             w_stall;

  // A start in E is accepted from IDLE or DONE; an excepting M-stage kills it.
  assign w_md_accept = (r_state != MD_BUSY) & md_start_E & ~exc_req_M;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      MD_IDLE, MD_DONE: begin
        if (w_md_accept) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = md_is_div_E ? DIV_CNT : MULT_CNT;
        end else begin
          w_state_nxt = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = MD_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign md_busy = (r_state == MD_BUSY);
  assign md_done = (r_state == MD_DONE);

  // md_start_E counts as busy in the same cycle so a dependent mfhi/mflo in D
  // never slips past the op being launched beside it.
  assign w_md_stall = md_use_D & (md_busy | (md_start_E & ~exc_req_M));
  assign w_stall    = stall_req | w_md_stall;

  // Controls are held inactive while reset is asserted.
  always_comb begin
    en_PC       = 1'b0;
    en_FD       = 1'b0;
    clr_FD      = 1'b0;
    clr_DE      = 1'b0;
    clr_EM      = 1'b0;
    en_MW       = 1'b0;
    clr_MW      = 1'b0;
    npc_sel     = NPC_SEQ;
    redirect_pc = '0;
    if (reset) begin
      if (exc_req_M) begin
        en_PC       = 1'b1;
        en_FD       = 1'b1;
        en_MW       = 1'b1;
        clr_FD      = 1'b1;
        clr_DE      = 1'b1;
        clr_EM      = 1'b1;
        clr_MW      = 1'b1;
        npc_sel     = NPC_EXC;
        redirect_pc = EXC_VEC;
      end else if (w_stall) begin
        clr_DE = 1'b1;
        en_MW  = 1'b1;
      end else if (eret_D) begin
        en_PC       = 1'b1;
        en_FD       = 1'b1;
        en_MW       = 1'b1;
        clr_FD      = 1'b1;
        npc_sel     = NPC_EPC;
        redirect_pc = epc;
      end else begin
        en_PC = 1'b1;
        en_FD = 1'b1;
        en_MW = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: control-priority vector table plus
// hand-written mult/div timing, reset and redirect sequences.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_req, md_use_D, md_start_E, md_is_div_E, exc_req_M, eret_D;
  logic [31:0] epc;
  logic        en_PC, en_FD, clr_FD, clr_DE, clr_EM, en_MW, clr_MW;
  logic [1:0]  npc_sel;
  logic [31:0] redirect_pc;
  logic        md_busy, md_done;

  int n_chk = 0;
  int n_err = 0;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .stall_req(stall_req), .md_use_D(md_use_D), .md_start_E(md_start_E),
    .md_is_div_E(md_is_div_E), .exc_req_M(exc_req_M), .eret_D(eret_D), .epc(epc),
    .en_PC(en_PC), .en_FD(en_FD), .clr_FD(clr_FD), .clr_DE(clr_DE),
    .clr_EM(clr_EM), .en_MW(en_MW), .clr_MW(clr_MW), .npc_sel(npc_sel),
    .redirect_pc(redirect_pc), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

  // {en_PC,en_FD,clr_FD,clr_DE,clr_EM,en_MW,clr_MW} ++ npc_sel ++ redirect_pc
  logic [40:0] w_ctl;
  assign w_ctl = {en_PC, en_FD, clr_FD, clr_DE, clr_EM, en_MW, clr_MW, npc_sel, redirect_pc};

  typedef struct {
    string       name;
    logic        stall_req, md_use_D, md_start_E, exc_req_M, eret_D;
    logic [31:0] epc;
    logic [6:0]  en_clr;
    logic [1:0]  sel;
    logic [31:0] rpc;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_in();
    stall_req = 0; md_use_D = 0; md_start_E = 0; md_is_div_E = 0;
    exc_req_M = 0; eret_D = 0; epc = 32'h0;
  endtask

  localparam logic [6:0] C_NORM  = 7'b1100010;
  localparam logic [6:0] C_STALL = 7'b0001010;
  localparam logic [6:0] C_ERET  = 7'b1110010;
  localparam logic [6:0] C_EXC   = 7'b1111111;

  vec_t vt[10];
  bit   saw_done;

  initial begin
    vt[0] = '{"normal",        0,0,0,0,0, 32'h0000_1234, C_NORM,  2'd0, 32'h0};
    vt[1] = '{"stall_req",     1,0,0,0,0, 32'h0000_1234, C_STALL, 2'd0, 32'h0};
    vt[2] = '{"eret",          0,0,0,0,1, 32'h0000_3010, C_ERET,  2'd2, 32'h0000_3010};
    vt[3] = '{"stall_eret",    1,0,0,0,1, 32'h0000_3010, C_STALL, 2'd0, 32'h0};
    vt[4] = '{"exc",           0,0,0,1,0, 32'h0000_3010, C_EXC,   2'd1, 32'h0000_4180};
    vt[5] = '{"exc_stall_eret",1,0,0,1,1, 32'h0000_3010, C_EXC,   2'd1, 32'h0000_4180};
    vt[6] = '{"md_use_idle",   0,1,0,0,0, 32'h0,         C_NORM,  2'd0, 32'h0};
    vt[7] = '{"exc_kills_mdst",0,1,1,1,0, 32'h0,         C_EXC,   2'd1, 32'h0000_4180};
    vt[8] = '{"eret_md_use",   0,1,0,0,1, 32'hBFC0_0380, C_ERET,  2'd2, 32'hBFC0_0380};
    vt[9] = '{"exc_start",     0,0,1,1,0, 32'h0,         C_EXC,   2'd1, 32'h0000_4180};

    idle_in();
    reset = 1'b0;

    // 1: reset held with a start request: everything stays 0
    md_start_E = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("rst_ctl", 64'(w_ctl), 64'h0);
      chk("rst_busy", 64'(md_busy), 64'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_busy", 64'(md_busy), 64'h1);
    md_start_E = 0;
    repeat (6) @(negedge clk);
    #1 chk("post_rst_idle", 64'({md_busy, md_done}), 64'h0);

    // control priority table (FSM stays idle throughout)
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle_in();
      stall_req = vt[i].stall_req; md_use_D = vt[i].md_use_D;
      md_start_E = vt[i].md_start_E; exc_req_M = vt[i].exc_req_M;
      eret_D = vt[i].eret_D; epc = vt[i].epc;
      #1 chk(vt[i].name, 64'(w_ctl), 64'({vt[i].en_clr, vt[i].sel, vt[i].rpc}));
    end
    @(negedge clk); idle_in();
    #1 chk("tbl_fsm_idle", 64'({md_busy, md_done}), 64'h0);

    // 2: mult at t, mflo in D behind it
    @(negedge clk);
    md_start_E = 1; md_is_div_E = 0; md_use_D = 1;
    #1 chk("mult_t_ctl", 64'({en_PC, clr_DE, md_busy}), 64'b010);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      md_start_E = 0;
      #1;
      if (k <= 5) chk($sformatf("mult_t%0d", k), 64'({md_busy, md_done, en_PC, clr_DE}), 64'b1001);
      else        chk("mult_t6",                 64'({md_busy, md_done, en_PC, clr_DE}), 64'b0110);
    end
    @(negedge clk); idle_in();
    #1 chk("mult_t7", 64'({md_busy, md_done}), 64'h0);

    // 3: div aborted by reset at t+4
    @(negedge clk);
    md_start_E = 1; md_is_div_E = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); md_start_E = 0;
      #1 chk($sformatf("div_t%0d", k), 64'(md_busy), 64'h1);
    end
    #1 reset = 1'b0;
    #1 chk("div_rst_busy", 64'(md_busy), 64'h0);
    @(negedge clk); reset = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (md_done || md_busy) saw_done = 1;
    end
    chk("div_rst_no_done", 64'(saw_done), 64'h0);

    // 4: eret held off by a stall, then redirects
    @(negedge clk);
    stall_req = 1; eret_D = 1; epc = 32'h0000_3010;
    #1 chk("eret_stalled", 64'({npc_sel, en_PC}), 64'b000);
    @(negedge clk); stall_req = 0;
    #1 chk("eret_go", 64'({npc_sel, redirect_pc, clr_FD}), {29'h0, 2'd2, 32'h0000_3010, 1'b1});

    // 5: exception beats everything and blocks the md start
    @(negedge clk);
    stall_req = 1; md_start_E = 1; md_is_div_E = 0; eret_D = 1; exc_req_M = 1; md_use_D = 1;
    #1 chk("exc_all", 64'(w_ctl), 64'({C_EXC, 2'd1, 32'h0000_4180}));
    @(negedge clk); idle_in();
    #1 chk("exc_md_idle", 64'(md_busy), 64'h0);

    // 6: exception mid-div does not abort; back-to-back mult in DONE
    @(negedge clk);
    md_start_E = 1; md_is_div_E = 1;
    saw_done = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      md_start_E = 0;
      exc_req_M = (k == 5);
      #1;
      if (md_done) saw_done = 1;
      if (k == 5 || k == 10) chk($sformatf("div_exc_t%0d", k), 64'(md_busy), 64'h1);
    end
    chk("div_no_early_done", 64'(saw_done), 64'h0);
    @(negedge clk);
    exc_req_M = 0; md_start_E = 1; md_is_div_E = 0;
    #1 chk("div_done_t11", 64'({md_busy, md_done}), 64'b01);
    @(negedge clk); md_start_E = 0;
    #1 chk("b2b_mult_busy", 64'({md_busy, md_done}), 64'b10);
    repeat (4) @(negedge clk);
    #1 chk("b2b_mult_last", 64'(md_busy), 64'h1);
    @(negedge clk);
    #1 chk("b2b_mult_done", 64'({md_busy, md_done}), 64'b01);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
